// File: rtl/id_ex_if.sv
// ============================================================================
// Module      : id_ex_if
// Description : Bundle of decode-side inputs, writeback bypass inputs and
//               execute-side outputs of the ID/EX pipeline register.
//               Optional counters appear when IDEX_PERF_CNT_EN is defined.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface id_ex_if #(
   parameter int XLEN = 32,
   parameter int RA_W = 5
);
   // Control from execute stage
   logic            FlushE;

   // Decode stage
   logic            validD;
   logic [XLEN-1:0] RD1D;
   logic [XLEN-1:0] RD2D;
   logic [RA_W-1:0] Rs1D;
   logic [RA_W-1:0] Rs2D;
   logic [RA_W-1:0] RdD;
   logic [XLEN-1:0] ImmExtD;
   logic [XLEN-1:0] PCD;
   logic [XLEN-1:0] PCPlus4D;
   logic            RegWriteD;
   logic            MemWriteD;
   logic [1:0]      ResultSrcD;
   logic [2:0]      ALUControlD;
   logic            ALUSrcD;
   logic            JumpD;
   logic            BranchD;

   // Writeback port (same values driving the register file)
   logic            RegWriteW;
   logic [RA_W-1:0] RdW;
   logic [XLEN-1:0] ResultW;

   // Execute stage
   logic            validE;
   logic [XLEN-1:0] RD1E;
   logic [XLEN-1:0] RD2E;
   logic [RA_W-1:0] Rs1E;
   logic [RA_W-1:0] Rs2E;
   logic [RA_W-1:0] RdE;
   logic [XLEN-1:0] ImmExtE;
   logic [XLEN-1:0] PCE;
   logic [XLEN-1:0] PCPlus4E;
   logic            RegWriteE;
   logic            MemWriteE;
   logic [1:0]      ResultSrcE;
   logic [2:0]      ALUControlE;
   logic            ALUSrcE;
   logic            JumpE;
   logic            BranchE;

   // Hazard outputs
   logic            StallF;
   logic            StallD;

`ifdef IDEX_PERF_CNT_EN
   logic [31:0]     StallCnt;
   logic [31:0]     FlushCnt;
`endif

   // Pipeline register side
   modport slave (
      input  FlushE, validD, RD1D, RD2D, Rs1D, Rs2D, RdD, ImmExtD, PCD, PCPlus4D,
             RegWriteD, MemWriteD, ResultSrcD, ALUControlD, ALUSrcD, JumpD, BranchD,
             RegWriteW, RdW, ResultW,
      output validE, RD1E, RD2E, Rs1E, Rs2E, RdE, ImmExtE, PCE, PCPlus4E,
             RegWriteE, MemWriteE, ResultSrcE, ALUControlE, ALUSrcE, JumpE, BranchE,
             StallF, StallD
`ifdef IDEX_PERF_CNT_EN
      , output StallCnt, FlushCnt
`endif
   );

   // Surrounding pipeline side
   modport master (
      output FlushE, validD, RD1D, RD2D, Rs1D, Rs2D, RdD, ImmExtD, PCD, PCPlus4D,
             RegWriteD, MemWriteD, ResultSrcD, ALUControlD, ALUSrcD, JumpD, BranchD,
             RegWriteW, RdW, ResultW,
      input  validE, RD1E, RD2E, Rs1E, Rs2E, RdE, ImmExtE, PCE, PCPlus4E,
             RegWriteE, MemWriteE, ResultSrcE, ALUControlE, ALUSrcE, JumpE, BranchE,
             StallF, StallD
`ifdef IDEX_PERF_CNT_EN
      , input StallCnt, FlushCnt
`endif
   );
endinterface

`default_nettype wire

// File: rtl/id_ex_stage.sv
// ============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register with same-cycle writeback bypass and
//               load-use hazard detection (stall F/D, bubble into E).
//               Optional stall/flush counters: define IDEX_PERF_CNT_EN.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module id_ex_stage #(
   parameter int XLEN = 32,
   parameter int RA_W = 5
) (
   input  wire logic clk,
   input  wire logic rst_n,
   id_ex_if.slave    bus
);

   localparam logic [1:0] C_SRC_LOAD = 2'b01;

   logic            valid_q,     valid_d;
   logic [XLEN-1:0] rd1_q,       rd1_d;
   logic [XLEN-1:0] rd2_q,       rd2_d;
   logic [RA_W-1:0] rs1_q,       rs1_d;
   logic [RA_W-1:0] rs2_q,       rs2_d;
   logic [RA_W-1:0] rd_q,        rd_d;
   logic [XLEN-1:0] imm_q,       imm_d;
   logic [XLEN-1:0] pc_q,        pc_d;
   logic [XLEN-1:0] pcp4_q,      pcp4_d;
   logic            regwrite_q,  regwrite_d;
   logic            memwrite_q,  memwrite_d;
   logic [1:0]      resultsrc_q, resultsrc_d;
   logic [2:0]      aluctl_q,    aluctl_d;
   logic            alusrc_q,    alusrc_d;
   logic            jump_q,      jump_d;
   logic            branch_q,    branch_d;

   logic            w_lw_stall;
   logic            w_stall;
   logic            w_bubble;

   // Hazard detection, bubble decision and writeback bypass of D operands
   always_comb begin
      w_lw_stall = valid_q && (resultsrc_q == C_SRC_LOAD) && (rd_q != '0) &&
                   ((rd_q == bus.Rs1D) || (rd_q == bus.Rs2D));
      w_stall    = w_lw_stall && !bus.FlushE;
      w_bubble   = bus.FlushE || w_lw_stall || !bus.validD;

      valid_d     = 1'b0;
      rd1_d       = '0;
      rd2_d       = '0;
      rs1_d       = '0;
      rs2_d       = '0;
      rd_d        = '0;
      imm_d       = '0;
      pc_d        = '0;
      pcp4_d      = '0;
      regwrite_d  = 1'b0;
      memwrite_d  = 1'b0;
      resultsrc_d = '0;
      aluctl_d    = '0;
      alusrc_d    = 1'b0;
      jump_d      = 1'b0;
      branch_d    = 1'b0;

      if (!w_bubble) begin
         valid_d     = 1'b1;
         // Register file writes on the edge; forward the writeback value so
         // the captured operand is not stale. x0 is hard-wired zero.
         rd1_d       = (bus.RegWriteW && (bus.RdW != '0) && (bus.RdW == bus.Rs1D))
                       ? bus.ResultW : bus.RD1D;
         rd2_d       = (bus.RegWriteW && (bus.RdW != '0) && (bus.RdW == bus.Rs2D))
                       ? bus.ResultW : bus.RD2D;
         rs1_d       = bus.Rs1D;
         rs2_d       = bus.Rs2D;
         rd_d        = bus.RdD;
         imm_d       = bus.ImmExtD;
         pc_d        = bus.PCD;
         pcp4_d      = bus.PCPlus4D;
         regwrite_d  = bus.RegWriteD;
         memwrite_d  = bus.MemWriteD;
         resultsrc_d = bus.ResultSrcD;
         aluctl_d    = bus.ALUControlD;
         alusrc_d    = bus.ALUSrcD;
         jump_d      = bus.JumpD;
         branch_d    = bus.BranchD;
      end
   end

   // E-stage register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q     <= 1'b0;
         rd1_q       <= '0;
         rd2_q       <= '0;
         rs1_q       <= '0;
         rs2_q       <= '0;
         rd_q        <= '0;
         imm_q       <= '0;
         pc_q        <= '0;
         pcp4_q      <= '0;
         regwrite_q  <= 1'b0;
         memwrite_q  <= 1'b0;
         resultsrc_q <= '0;
         aluctl_q    <= '0;
         alusrc_q    <= 1'b0;
         jump_q      <= 1'b0;
         branch_q    <= 1'b0;
      end else begin
         valid_q     <= valid_d;
         rd1_q       <= rd1_d;
         rd2_q       <= rd2_d;
         rs1_q       <= rs1_d;
         rs2_q       <= rs2_d;
         rd_q        <= rd_d;
         imm_q       <= imm_d;
         pc_q        <= pc_d;
         pcp4_q      <= pcp4_d;
         regwrite_q  <= regwrite_d;
         memwrite_q  <= memwrite_d;
         resultsrc_q <= resultsrc_d;
         aluctl_q    <= aluctl_d;
         alusrc_q    <= alusrc_d;
         jump_q      <= jump_d;
         branch_q    <= branch_d;
      end
   end

   // Drive E outputs from the register
   always_comb begin
      bus.validE      = valid_q;
      bus.RD1E        = rd1_q;
      bus.RD2E        = rd2_q;
      bus.Rs1E        = rs1_q;
      bus.Rs2E        = rs2_q;
      bus.RdE         = rd_q;
      bus.ImmExtE     = imm_q;
      bus.PCE         = pc_q;
      bus.PCPlus4E    = pcp4_q;
      bus.RegWriteE   = regwrite_q;
      bus.MemWriteE   = memwrite_q;
      bus.ResultSrcE  = resultsrc_q;
      bus.ALUControlE = aluctl_q;
      bus.ALUSrcE     = alusrc_q;
      bus.JumpE       = jump_q;
      bus.BranchE     = branch_q;
      bus.StallF      = w_stall;
      bus.StallD      = w_stall;
   end

`ifdef IDEX_PERF_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] flush_cnt_q, flush_cnt_d;

   // Event counters; natural 32-bit wrap
   always_comb begin
      stall_cnt_d = stall_cnt_q + {31'd0, w_stall};
      flush_cnt_d = flush_cnt_q + {31'd0, bus.FlushE};
   end

   // Counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // Counter outputs
   always_comb begin
      bus.StallCnt = stall_cnt_q;
      bus.FlushCnt = flush_cnt_q;
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// ============================================================================
// Module      : tb_id_ex_stage
// Description : Scoreboard bench for id_ex_stage. Expected E records are
//               computed from a reference model when D is driven, queued,
//               and compared after the capturing edge.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_id_ex_stage;
   localparam int XLEN = 32;
   localparam int RA_W = 5;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] rd1;
      logic [XLEN-1:0] rd2;
      logic [RA_W-1:0] rs1;
      logic [RA_W-1:0] rs2;
      logic [RA_W-1:0] rd;
      logic [XLEN-1:0] imm;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pcp4;
      logic            regwrite;
      logic            memwrite;
      logic [1:0]      resultsrc;
      logic [2:0]      aluctl;
      logic            alusrc;
      logic            jump;
      logic            branch;
   } e_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   e_t   m_e;
   e_t   sb_q[$];
   logic [31:0] m_stall_cnt;
   logic [31:0] m_flush_cnt;

   id_ex_if #(.XLEN(XLEN), .RA_W(RA_W)) bus ();

   id_ex_stage #(.XLEN(XLEN), .RA_W(RA_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic e_t dut_e();
      e_t r;
      r.valid     = bus.validE;
      r.rd1       = bus.RD1E;
      r.rd2       = bus.RD2E;
      r.rs1       = bus.Rs1E;
      r.rs2       = bus.Rs2E;
      r.rd        = bus.RdE;
      r.imm       = bus.ImmExtE;
      r.pc        = bus.PCE;
      r.pcp4      = bus.PCPlus4E;
      r.regwrite  = bus.RegWriteE;
      r.memwrite  = bus.MemWriteE;
      r.resultsrc = bus.ResultSrcE;
      r.aluctl    = bus.ALUControlE;
      r.alusrc    = bus.ALUSrcE;
      r.jump      = bus.JumpE;
      r.branch    = bus.BranchE;
      return r;
   endfunction

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_e(input string tag, input e_t obs, input e_t exp);
      chk(tag, 256'(obs), 256'(exp));
   endtask

   task automatic chk_cnt();
`ifdef IDEX_PERF_CNT_EN
      chk("StallCnt", 256'(bus.StallCnt), 256'(m_stall_cnt));
      chk("FlushCnt", 256'(bus.FlushCnt), 256'(m_flush_cnt));
`endif
   endtask

   task automatic model_reset();
      m_e         = '0;
      sb_q.delete();
      m_stall_cnt = '0;
      m_flush_cnt = '0;
   endtask

   // One D->E cycle: check stall outputs, predict E, clock, compare
   task automatic step(input string tag);
      e_t   exp;
      e_t   got;
      logic lw;
      logic bubble;
      #1;
      lw = m_e.valid && (m_e.resultsrc == 2'b01) && (m_e.rd != 0) &&
           ((m_e.rd == bus.Rs1D) || (m_e.rd == bus.Rs2D));
      chk({tag, ".StallF"}, 256'(bus.StallF), 256'(lw && !bus.FlushE));
      chk({tag, ".StallD"}, 256'(bus.StallD), 256'(lw && !bus.FlushE));
      bubble = bus.FlushE || lw || !bus.validD;
      exp = '0;
      if (!bubble) begin
         exp.valid     = 1'b1;
         exp.rd1       = (bus.RegWriteW && bus.RdW != 0 && bus.RdW == bus.Rs1D) ? bus.ResultW : bus.RD1D;
         exp.rd2       = (bus.RegWriteW && bus.RdW != 0 && bus.RdW == bus.Rs2D) ? bus.ResultW : bus.RD2D;
         exp.rs1       = bus.Rs1D;
         exp.rs2       = bus.Rs2D;
         exp.rd        = bus.RdD;
         exp.imm       = bus.ImmExtD;
         exp.pc        = bus.PCD;
         exp.pcp4      = bus.PCPlus4D;
         exp.regwrite  = bus.RegWriteD;
         exp.memwrite  = bus.MemWriteD;
         exp.resultsrc = bus.ResultSrcD;
         exp.aluctl    = bus.ALUControlD;
         exp.alusrc    = bus.ALUSrcD;
         exp.jump      = bus.JumpD;
         exp.branch    = bus.BranchD;
      end
      sb_q.push_back(exp);
      if (lw && !bus.FlushE) m_stall_cnt++;
      if (bus.FlushE) m_flush_cnt++;
      m_e = exp;
      @(posedge clk);
      #1;
      got = dut_e();
      if (sb_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s: scoreboard empty observed %h expected entry", tag, got);
      end else begin
         chk_e({tag, ".E"}, got, sb_q.pop_front());
      end
      chk_cnt();
   endtask

   task automatic set_d(input logic [XLEN-1:0] r1, input logic [XLEN-1:0] r2,
                        input logic [RA_W-1:0] s1, input logic [RA_W-1:0] s2,
                        input logic [RA_W-1:0] d, input logic [1:0] src);
      bus.validD      = 1'b1;
      bus.RD1D        = r1;
      bus.RD2D        = r2;
      bus.Rs1D        = s1;
      bus.Rs2D        = s2;
      bus.RdD         = d;
      bus.ResultSrcD  = src;
      bus.RegWriteD   = 1'b1;
      bus.ImmExtD     = r1 ^ 32'h0F0F_0000;
      bus.PCD         = {r2[29:0], 2'b00};
      bus.PCPlus4D    = {r2[29:0], 2'b00} + 32'd4;
      bus.ALUControlD = r1[2:0];
      bus.ALUSrcD     = r2[0];
      bus.MemWriteD   = r1[3];
      bus.JumpD       = r1[4];
      bus.BranchD     = r2[4];
   endtask

   initial begin
      checks = 0;
      errors = 0;
      model_reset();
      bus.FlushE = 0; bus.RegWriteW = 0; bus.RdW = 0; bus.ResultW = 0;
      set_d(32'h55, 32'h66, 5'd1, 5'd2, 5'd9, 2'b00);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_e("reset.E", dut_e(), '0);
      chk("reset.StallD", 256'(bus.StallD), 256'd0);
      chk_cnt();
      rst_n = 1'b1;

      // Pass-through, no writeback
      set_d(32'h11, 32'h22, 5'd1, 5'd2, 5'd5, 2'b00);
      step("pass");

      // Mid-cycle reset while E holds a valid instruction
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      chk_e("midreset.E", dut_e(), '0);
      chk("midreset.StallF", 256'(bus.StallF), 256'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Writeback bypass on each operand, x0 never bypassed
      set_d(32'hDEAD, 32'hBEEF, 5'd7, 5'd8, 5'd6, 2'b00);
      bus.RegWriteW = 1; bus.RdW = 5'd7; bus.ResultW = 32'h1234;
      step("bypass1");
      bus.RdW = 5'd0;
      step("nobypass_rdw0");
      bus.RdW = 5'd8; bus.ResultW = 32'h5678;
      step("bypass2");
      set_d(32'hDEAD, 32'hBEEF, 5'd0, 5'd0, 5'd6, 2'b00);
      bus.RdW = 5'd0; bus.ResultW = 32'h9999;
      step("x0_bypass");
      bus.RegWriteW = 0;
      step("wb_disabled");

      // Load-use: load to x3, then consumer of x3 via Rs2D
      set_d(32'h100, 32'h200, 5'd1, 5'd2, 5'd3, 2'b01);
      step("load");
      set_d(32'h300, 32'h400, 5'd4, 5'd3, 5'd10, 2'b00);
      step("loaduse_stall");
      step("loaduse_release");
      step("after_release");

      // Flush wins over the load-use stall
      set_d(32'h100, 32'h200, 5'd1, 5'd2, 5'd3, 2'b01);
      step("load2");
      set_d(32'h500, 32'h600, 5'd3, 5'd1, 5'd11, 2'b00);
      bus.FlushE = 1;
      step("flush_vs_stall");
      bus.FlushE = 0;

      // Load to x0 never stalls
      set_d(32'h100, 32'h200, 5'd1, 5'd2, 5'd0, 2'b01);
      step("load_x0");
      set_d(32'h700, 32'h800, 5'd0, 5'd0, 5'd12, 2'b00);
      step("x0_nostall");

      // Invalid D produces a bubble
      bus.validD = 0;
      step("invalid_d");

      // Reset in the middle of a stall
      set_d(32'h100, 32'h200, 5'd1, 5'd2, 5'd4, 2'b01);
      step("load3");
      set_d(32'h900, 32'hA00, 5'd4, 5'd5, 5'd13, 2'b00);
      #1;
      chk("prestall.StallD", 256'(bus.StallD), 256'd1);
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("resetstall.StallF", 256'(bus.StallF), 256'd0);
      chk("resetstall.StallD", 256'(bus.StallD), 256'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Random mix with a small register range to provoke hazards
      for (int i = 0; i < 60; i++) begin
         set_d($urandom, $urandom, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)), 2'($urandom_range(0, 2)));
         bus.validD    = ($urandom_range(0, 7) != 0);
         bus.FlushE    = ($urandom_range(0, 7) == 0);
         bus.RegWriteW = $urandom_range(0, 1) == 1;
         bus.RdW       = 5'($urandom_range(0, 3));
         bus.ResultW   = $urandom;
         step("random");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register. Sits directly downstream of the register file read ports (RD1D/RD2D) in the 5-stage RV32I pipeline.
- Captures the operands, register addresses, immediate, PC and control for the execute stage.
- Bypasses a same-cycle writeback, because the register file writes on the clock edge and reads combinationally.
- Detects load-use hazards: stalls fetch/decode and inserts a bubble into execute.

Parameters:
XLEN, 32, datapath width
RA_W, 5, register address width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
FlushE  in  1  branch/jump taken in E; kill instruction entering E
validD  in  1  D holds a real instruction
RD1D  in  XLEN  register file read data 1
RD2D  in  XLEN  register file read data 2
Rs1D  in  RA_W  source register 1
Rs2D  in  RA_W  source register 2
RdD  in  RA_W  destination register
ImmExtD  in  XLEN  sign-extended immediate
PCD  in  XLEN  PC of D instruction
PCPlus4D  in  XLEN  PC+4 of D instruction
RegWriteD  in  1  control
MemWriteD  in  1  control
ResultSrcD  in  2  00 ALU, 01 load, 10 PC+4
ALUControlD  in  3  control
ALUSrcD  in  1  control
JumpD  in  1  control
BranchD  in  1  control
RegWriteW  in  1  writeback enable (same signal driving register file)
RdW  in  RA_W  writeback destination
ResultW  in  XLEN  writeback data
validE, RD1E, RD2E, Rs1E, Rs2E, RdE, ImmExtE, PCE, PCPlus4E, RegWriteE, MemWriteE, ResultSrcE, ALUControlE, ALUSrcE, JumpE, BranchE  out  (same widths as D counterparts)  registered E-stage copies
StallF  out  1  hold PC
StallD  out  1  hold IF/ID register

Behaviour:
- Reset: async on rst_n low. All outputs registered to 0: validE=0, all data and control fields 0 (bubble).
- Load-use detection (combinational on E state and D inputs):
  - lwStall = validE & (ResultSrcE==01) & (RdE!=0) & ((RdE==Rs1D) | (RdE==Rs2D)).
  - StallF = StallD = lwStall & ~FlushE.
- Bubble condition: bubble = FlushE | lwStall | ~validD.
- At each rising edge, if bubble:
  - validE, RegWriteE, MemWriteE, JumpE, BranchE, ResultSrcE, ALUControlE, ALUSrcE <= 0.
  - Data fields (RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE) <= 0.
- Otherwise, capture all D fields, with writeback bypass:
  - RD1E <= (RegWriteW & RdW!=0 & RdW==Rs1D) ? ResultW : RD1D; RD2E likewise with Rs2D.
  - x0 is never bypassed.
- Latency: one cycle D->E.
- Stall is single-cycle by construction: after the bubble, E is no longer a load, so lwStall drops. The held D instruction enters E next edge and picks up the loaded value via the W bypass or the downstream forward.
- FlushE and lwStall together: bubble. Stall outputs are suppressed (FlushE wins); the D instruction is wrong-path.
- Rs1D or Rs2D = 0 matching RdE = 0: no stall.
- Reset mid-stall: StallF/StallD drop immediately, since they derive from the now-zero E state.

Optional Feature:
- Macro IDEX_PERF_CNT_EN.
- Defined:
  - Adds outputs StallCnt[31:0] and FlushCnt[31:0], reset to 0.
  - StallCnt increments on each edge where StallD=1.
  - FlushCnt increments on each edge where FlushE=1.
  - Both wrap at 0xFFFFFFFF -> 0.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset: rst_n=0 mid-cycle with validD=1, RegWriteD=1 -> all E outputs 0 immediately, StallF=StallD=0.
- Pass-through: validD=1, RD1D=0x11, RD2D=0x22, RdD=5, RegWriteD=1, no W write -> next edge RD1E=0x11, RD2E=0x22, RdE=5, validE=1.
- WB bypass: Rs1D=7, RD1D=0xDEAD, RegWriteW=1, RdW=7, ResultW=0x1234 -> RD1E=0x1234. Same with RdW=0 -> RD1E=0xDEAD.
- Load-use: E holds load, RdE=3; D has Rs2D=3 -> StallF=StallD=1 for exactly one cycle. Next edge validE=0, RegWriteE=0. Following edge the D instruction enters E.
- Flush priority: FlushE=1 while the lwStall condition holds -> StallD=0, bubble in E. With IDEX_PERF_CNT_EN: FlushCnt +1, StallCnt unchanged.
- x0 hazard: load with RdE=0 followed by Rs1D=0 -> no stall, normal capture.
